recomposer_nbits: RTL and testbench
===================================

Name: recomposer_nbits

Overview:
- Sequential inverse of the ALU modulo operation: rebuilds the dividend as a = q*b + r from a quotient, divisor and remainder.
- Uses an N-cycle shift-add datapath with a start/busy/done handshake.
- Outputs the same four ALU flags (neg, zr, cry, of) so it can feed the existing flag register and display path.
- Used to self-check divide/modulo results and as the ALU's multi-cycle multiply-accumulate slot.

Parameters:
- N, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- q  input  N  quotient (multiplier), unsigned
- b  input  N  divisor (multiplicand), unsigned
- r  input  N  remainder (addend), unsigned
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when result and flags become valid
- result  output  N  low N bits of q*b + r
- neg_flag  output  1  result[N-1]
- zr_flag  output  1  result == 0
- cry_flag  output  1  q*b + r does not fit in N bits (any bit of acc[2N-1:N] set)
- of_flag  output  1  inconsistent remainder: b != 0 and r >= b; also 1 when b == 0 and r != 0

Behaviour:
- Reset (async, rst_n low): state=IDLE, busy=0, done=0, result=0, all flags=0, internal registers=0.
- States are IDLE, CALC and DONE.
- IDLE:
  - On an edge with start=1: capture acc={N'0,r} (2N bits), mcand={N'0,b} (2N bits), mult=q, cnt=0; go to CALC.
  - Operands are sampled only at this edge.
- CALC (busy=1), each edge:
  - If mult[0], acc += mcand.
  - Then mcand <<= 1, mult >>= 1, cnt++.
  - After the Nth CALC edge (cnt reaches N), go to DONE.
  - Register result=acc_next[N-1:0]; compute flags from acc_next and the captured b and r.
- DONE (busy=0, done=1 for exactly this cycle): next edge returns to IDLE.
- start is ignored in CALC and DONE. There is no queueing.
- Latency: start sampled at edge k -> done high in the cycle after edge k+N. The next start is accepted at edge k+N+2 or later.
- result and flags hold their last values from DONE until the next DONE. They are not cleared by a new start.
- Width rule: a 2N-bit accumulator never overflows, since max = (2^N-1)^2 + 2^N-1 < 2^2N.
- b=0 or q=0 is a legal operation: the product term is 0 and result = r.
- Reset mid-CALC aborts the operation immediately: done does not pulse and outputs return to reset values.

Optional Feature:
- Macro: RECOMPOSER_EARLY_TERM_EN.
- Defined: CALC also exits to DONE on any edge where mult_next == 0. There is a minimum of 1 CALC cycle; latency = max(1, position of the highest set bit of q + 1) + 1 cycles. Result and flags are identical to the non-terminated case.
- Undefined: fixed latency of N CALC cycles, as described above.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} recomp_state_t
  - a function computing the flag vector {neg, zr, cry, of}, reusable by the other ALU op modules.
- One natural sub-module, shift_add_step: combinational, takes acc/mcand/mult and produces their next values, with widths parameterised by N.
- The FSM, counter and output registers stay in recomposer_nbits.

Test Plan:
- N=8, q=12, b=7, r=5, start pulse -> busy high 8 cycles, done 1 cycle, result=89, neg=0, zr=0, cry=0, of=0.
- N=4, q=15, b=15, r=15 -> acc=240; result=0, zr=1, cry=1, of=1, neg=0.
- N=4, q=2, b=4, r=6 -> result=14, neg=1, of=1, cry=0; q=0, b=0, r=0 -> result=0, zr=1, of=0.
- N=4, start held high across CALC with changed q/b/r -> inputs ignored, result uses values captured at the first edge; the next operation starts only after returning to IDLE.
- N=8, rst_n low in the 3rd CALC cycle -> busy=0, result=0, flags=0 immediately, no done pulse; a subsequent start completes normally.
- With RECOMPOSER_EARLY_TERM_EN defined, N=8: q=1 -> 1 CALC cycle; q=0 -> 1 CALC cycle; q=128 -> 8 CALC cycles; results match the non-terminated build.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: recomposer state encoding and the common {neg, zr, cry, of} flag function.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} recomp_state_t;

    localparam int ALU_MAX_W = 32;

    // acc is the full-width result zero-extended to 2*ALU_MAX_W; n is the op width.
    function automatic logic [3:0] alu_flags(
        input logic [2*ALU_MAX_W-1:0] acc,
        input logic [ALU_MAX_W-1:0]   b,
        input logic [ALU_MAX_W-1:0]   r,
        input int unsigned            n
    );
        logic [2*ALU_MAX_W-1:0] lo_mask;
        logic neg;
        logic zr;
        logic cry;
        logic of;
        lo_mask = (64'd1 << n) - 64'd1;
        neg     = acc[6'(n - 1)];
        zr      = (acc & lo_mask) == '0;
        cry     = (acc & ~lo_mask) != '0;
        of      = (b != '0) ? (r >= b) : (r != '0);
        return {neg, zr, cry, of};
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One combinational shift-add multiply step: conditional add, then shift multiplicand left and multiplier right.
module shift_add_step #(
    parameter int N = 4
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] mcand,
    input  logic [N-1:0]   mult,
    output logic [2*N-1:0] acc_next,
    output logic [2*N-1:0] mcand_next,
    output logic [N-1:0]   mult_next
);

    assign acc_next   = mult[0] ? (acc + mcand) : acc;
    assign mcand_next = mcand << 1;
    assign mult_next  = mult >> 1;

endmodule

// File: rtl/recomposer_nbits.sv
// Multi-cycle recomposer a = q*b + r with start/busy/done handshake and ALU flags.
// Optional early termination when the multiplier runs out of set bits: RECOMPOSER_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | one shift-add step per edge, busy high
// DONE  | result and flags valid, done high for this one cycle
module recomposer_nbits
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] q,
    input  logic [N-1:0] b,
    input  logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         neg_flag,
    output logic         zr_flag,
    output logic         cry_flag,
    output logic         of_flag
);

    localparam int CW = $clog2(N + 1);

    recomp_state_t state;
    recomp_state_t state_next;

    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mult;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   b_cap;
    logic [N-1:0]   r_cap;
    logic [3:0]     flags_q;

    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] mcand_next;
    logic [N-1:0]   mult_next;
    logic           last_step;

    shift_add_step #(.N(N)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mult       (mult),
        .acc_next   (acc_next),
        .mcand_next (mcand_next),
        .mult_next  (mult_next)
    );

    always_comb begin
        last_step = (cnt == CW'(N - 1));
`ifdef RECOMPOSER_EARLY_TERM_EN
        // No set bits left means every further step would add nothing.
        last_step = last_step || (mult_next == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mult    <= '0;
            cnt     <= '0;
            b_cap   <= '0;
            r_cap   <= '0;
            result  <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= {{N{1'b0}}, r};
                        mcand <= {{N{1'b0}}, b};
                        mult  <= q;
                        cnt   <= '0;
                        b_cap <= b;
                        r_cap <= r;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand_next;
                    mult  <= mult_next;
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        result  <= acc_next[N-1:0];
                        flags_q <= alu_flags(64'(acc_next), 32'(b_cap), 32'(r_cap), N);
                    end
                end
                default: ;
            endcase
        end
    end

    assign neg_flag = flags_q[3];
    assign zr_flag  = flags_q[2];
    assign cry_flag = flags_q[1];
    assign of_flag  = flags_q[0];

endmodule

// File: tb/tb_recomposer_nbits.sv
// Self-checking bench for recomposer_nbits: an N=8 and an N=4 instance checked every cycle against a timestamp model.
module tb_recomposer_nbits;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       start_v [2];
    logic [7:0] q_v [2];
    logic [7:0] b_v [2];
    logic [7:0] r_v [2];

    logic       busy8, done8, neg8, zr8, cry8, of8;
    logic [7:0] res8;
    logic       busy4, done4, neg4, zr4, cry4, of4;
    logic [3:0] res4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    recomposer_nbits #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .q(q_v[0]), .b(b_v[0]), .r(r_v[0]),
        .busy(busy8), .done(done8), .result(res8),
        .neg_flag(neg8), .zr_flag(zr8), .cry_flag(cry8), .of_flag(of8)
    );

    recomposer_nbits #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .q(q_v[1][3:0]), .b(b_v[1][3:0]), .r(r_v[1][3:0]),
        .busy(busy4), .done(done4), .result(res4),
        .neg_flag(neg4), .zr_flag(zr4), .cry_flag(cry4), .of_flag(of4)
    );

`ifdef RECOMPOSER_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint calc_len(input int w, input logic [7:0] qq);
        longint len;
        len = longint'(w);
        if (EARLY) begin
            len = 1;
            for (int i = 0; i < w; i++)
                if (qq[i]) len = longint'(i + 1);
        end
        return len;
    endfunction

    function automatic logic [7:0] model_res(input int w, input logic [7:0] qq, bb, rr);
        longint unsigned full;
        full = 64'(qq) * 64'(bb) + 64'(rr);
        return 8'(full & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [3:0] model_flg(input int w, input logic [7:0] qq, bb, rr);
        longint unsigned full, mask, res;
        full = 64'(qq) * 64'(bb) + 64'(rr);
        mask = (64'd1 << w) - 64'd1;
        res  = full & mask;
        return {res[w-1], res == 0, full > mask, (bb == 0) ? (rr != 0) : (rr >= bb)};
    endfunction

    // Model: an op accepted at edge k is busy after edges k..k+L-1, done after k+L, free again at k+L+2.
    int          width_d [2] = '{8, 4};
    longint      ec = 0;
    longint      k_s [2]     = '{0, 0};
    longint      l_s [2]     = '{0, 0};
    longint      free_at [2] = '{0, 0};
    bit          active [2]  = '{0, 0};
    logic [7:0]  pend_res [2] = '{0, 0};
    logic [3:0]  pend_flg [2] = '{0, 0};
    logic [7:0]  held_res [2] = '{0, 0};
    logic [3:0]  held_flg [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                active[d]   <= 1'b0;
                free_at[d]  <= 0;
                held_res[d] <= '0;
                held_flg[d] <= '0;
            end
        end else begin
            ec <= ec + 1;
            for (int d = 0; d < 2; d++) begin
                if (active[d] && (ec + 1 == k_s[d] + l_s[d])) begin
                    held_res[d] <= pend_res[d];
                    held_flg[d] <= pend_flg[d];
                end
                if ((ec + 1 >= free_at[d]) && start_v[d]) begin
                    k_s[d]      <= ec + 1;
                    l_s[d]      <= calc_len(width_d[d], q_v[d]);
                    free_at[d]  <= ec + 1 + calc_len(width_d[d], q_v[d]) + 2;
                    pend_res[d] <= model_res(width_d[d], q_v[d], b_v[d], r_v[d]);
                    pend_flg[d] <= model_flg(width_d[d], q_v[d], b_v[d], r_v[d]);
                    active[d]   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("n%0d busy", width_d[d]), 32'(d == 0 ? busy8 : busy4),
                  32'(active[d] && ec >= k_s[d] && ec < k_s[d] + l_s[d]));
            check($sformatf("n%0d done", width_d[d]), 32'(d == 0 ? done8 : done4),
                  32'(active[d] && ec == k_s[d] + l_s[d]));
            check($sformatf("n%0d result", width_d[d]), 32'(d == 0 ? res8 : {4'b0, res4}),
                  32'(held_res[d]));
            check($sformatf("n%0d flags", width_d[d]),
                  32'(d == 0 ? {neg8, zr8, cry8, of8} : {neg4, zr4, cry4, of4}),
                  32'(held_flg[d]));
        end
    end

    task automatic wait_done(input int d, output int bc);
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d == 0 ? busy8 : busy4) bc++;
            if (d == 0 ? done8 : done4) return;
        end
        checks++;
        errors++;
        $display("FAIL done timeout on n%0d after 100 cycles, required a done pulse", width_d[d]);
    endtask

    task automatic run_op(input int d, input logic [7:0] qq, bb, rr, output int bc);
        @(posedge clk); #2;
        start_v[d] = 1'b1;
        q_v[d] = qq; b_v[d] = bb; r_v[d] = rr;
        @(posedge clk); #2;
        start_v[d] = 1'b0;
        wait_done(d, bc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, required the run to end");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; q_v[d] = '0; b_v[d] = '0; r_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset result", 32'(res8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);

        run_op(0, 8'd12, 8'd7, 8'd5, bc);
        check("12*7+5 result", 32'(res8), 32'd89);
        check("12*7+5 flags", 32'({neg8, zr8, cry8, of8}), 32'b0000);
        check("12*7+5 busy cycles", 32'(bc), EARLY ? 32'd4 : 32'd8);

        run_op(1, 8'd15, 8'd15, 8'd15, bc);
        check("15*15+15 result", 32'(res4), 32'd0);
        check("15*15+15 flags", 32'({neg4, zr4, cry4, of4}), 32'b0111);

        run_op(1, 8'd2, 8'd4, 8'd6, bc);
        check("2*4+6 result", 32'(res4), 32'd14);
        check("2*4+6 flags", 32'({neg4, zr4, cry4, of4}), 32'b1001);

        run_op(1, 8'd0, 8'd0, 8'd0, bc);
        check("0*0+0 result", 32'(res4), 32'd0);
        check("0*0+0 flags", 32'({neg4, zr4, cry4, of4}), 32'b0100);

        // start held high; operands change after capture
        @(posedge clk); #2;
        start_v[1] = 1'b1; q_v[1] = 8'd3; b_v[1] = 8'd5; r_v[1] = 8'd2;
        @(posedge clk); #2;
        q_v[1] = 8'd7; b_v[1] = 8'd7; r_v[1] = 8'd1;
        wait_done(1, bc);
        check("held first result", 32'(res4), 32'd1);
        check("held first flags", 32'({neg4, zr4, cry4, of4}), 32'b0010);
        wait_done(1, bc);
        check("held second result", 32'(res4), 32'd2);
        check("held second flags", 32'({neg4, zr4, cry4, of4}), 32'b0010);
        @(posedge clk); #2;
        start_v[1] = 1'b0;

        // reset during the 3rd CALC cycle
        @(posedge clk); #2;
        start_v[0] = 1'b1; q_v[0] = 8'd200; b_v[0] = 8'd3; r_v[0] = 8'd1;
        @(posedge clk); #2;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("pre-reset busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort result", 32'(res8), 32'd0);
        check("abort flags", 32'({neg8, zr8, cry8, of8}), 32'b0000);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(0, 8'd255, 8'd255, 8'd255, bc);
        check("255*255+255 result", 32'(res8), 32'd0);
        check("255*255+255 flags", 32'({neg8, zr8, cry8, of8}), 32'b0111);

        run_op(0, 8'd1, 8'd9, 8'd3, bc);
        check("1*9+3 result", 32'(res8), 32'd12);
        check("1*9+3 busy cycles", 32'(bc), EARLY ? 32'd1 : 32'd8);
        run_op(0, 8'd0, 8'd5, 8'd4, bc);
        check("0*5+4 result", 32'(res8), 32'd4);
        check("0*5+4 flags", 32'({neg8, zr8, cry8, of8}), 32'b0000);
        check("0*5+4 busy cycles", 32'(bc), EARLY ? 32'd1 : 32'd8);
        run_op(0, 8'd128, 8'd2, 8'd1, bc);
        check("128*2+1 result", 32'(res8), 32'd1);
        check("128*2+1 flags", 32'({neg8, zr8, cry8, of8}), 32'b0010);
        check("128*2+1 busy cycles", 32'(bc), 32'd8);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
